// File: rtl/n101_subsys_bpty_errctl_if.sv
// rtl/n101_subsys_bpty_errctl_if.sv - parity-error event inputs and error-log outputs
interface n101_subsys_bpty_errctl_if #(
  parameter int ADDR_SIZE = 32,
  parameter int CNT_W     = 8
);
  logic                     bptylvl;
  logic [2:0]               err_vld;
  logic [5:0]               err_type;
  logic [3*ADDR_SIZE-1:0]   err_addr;
  logic                     log_clr;
  logic                     log_vld;
  logic [1:0]               log_src;
  logic [1:0]               log_type;
  logic [ADDR_SIZE-1:0]     log_addr;
  logic [CNT_W-1:0]         err_cnt;
  logic [2:0]               ovf;
  logic                     bpty_fatal;

  modport master (
    output bptylvl, err_vld, err_type, err_addr, log_clr,
    input  log_vld, log_src, log_type, log_addr, err_cnt, ovf, bpty_fatal
  );

  modport slave (
    input  bptylvl, err_vld, err_type, err_addr, log_clr,
    output log_vld, log_src, log_type, log_addr, err_cnt, ovf, bpty_fatal
  );
endinterface

// File: rtl/n101_subsys_bpty_errctl.sv
// rtl/n101_subsys_bpty_errctl.sv - ILM/DLM/MEM parity-error buffering, round-robin logging and fatal escalation
module n101_subsys_bpty_errctl #(
  parameter int ADDR_SIZE  = 32,
  parameter int CNT_W      = 8,
  parameter int ESC_THRESH = 4
) (
  input logic                        clk,
  input logic                        rst,
  n101_subsys_bpty_errctl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOGGED = 2'd1,
    ST_FATAL  = 2'd2
  } state_t;

  localparam logic [CNT_W+1:0] CNT_MAX    = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CNT_W+1:0] THRESH_EXT = (CNT_W+2)'(ESC_THRESH);

  state_t state, state_nxt;

  logic [2:0]           pend;
  logic [1:0]           pend_type [3];
  logic [ADDR_SIZE-1:0] pend_addr [3];
  logic [1:0]           rr_ptr;

  logic [2:0]           gnt;
  logic [1:0]           gnt_idx;
  logic                 gnt_any;

  logic [1:0]           pop;
  logic [CNT_W+1:0]     cnt_sum;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 thresh_hit;

  logic                 log_vld_q;
  logic [1:0]           log_src_q;
  logic [1:0]           log_type_q;
  logic [ADDR_SIZE-1:0] log_addr_q;
  logic [CNT_W-1:0]     err_cnt_q;
  logic [2:0]           ovf_q;
  logic                 fatal_q;

  assign bus.log_vld    = log_vld_q;
  assign bus.log_src    = log_src_q;
  assign bus.log_type   = log_type_q;
  assign bus.log_addr   = log_addr_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.ovf        = ovf_q;
  assign bus.bpty_fatal = fatal_q;

  // Round-robin search starting at rr_ptr; only IDLE may grant.
  always_comb begin
    logic [2:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (state == ST_IDLE) begin
      for (int k = 0; k < 3; k++) begin
        cand = {1'b0, rr_ptr} + 3'(k);
        if (cand >= 3'd3) cand = cand - 3'd3;
        if (!gnt_any && pend[cand[1:0]]) begin
          gnt_any             = 1'b1;
          gnt_idx             = cand[1:0];
          gnt[cand[1:0]]      = 1'b1;
        end
      end
    end
  end

  // Dropped events still count, so the sum uses raw err_vld.
  always_comb begin
    pop        = {1'b0, bus.err_vld[0]} + {1'b0, bus.err_vld[1]} + {1'b0, bus.err_vld[2]};
    cnt_sum    = {2'b00, err_cnt_q} + {{CNT_W{1'b0}}, pop};
    cnt_nxt    = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    thresh_hit = ({2'b00, cnt_nxt} >= THRESH_EXT);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_any) state_nxt = bus.bptylvl ? ST_FATAL : ST_LOGGED;
        if (thresh_hit) state_nxt = ST_FATAL;
      end
      ST_LOGGED: begin
        if (bus.log_clr) state_nxt = ST_IDLE;
        if (thresh_hit) state_nxt = ST_FATAL;
      end
      ST_FATAL: state_nxt = ST_FATAL;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      log_vld_q  <= 1'b0;
      log_src_q  <= '0;
      log_type_q <= '0;
      log_addr_q <= '0;
      err_cnt_q  <= '0;
      fatal_q    <= 1'b0;
    end else begin
      err_cnt_q <= cnt_nxt;
      fatal_q   <= (state_nxt == ST_FATAL);
      if (gnt_any) begin
        rr_ptr     <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        log_vld_q  <= 1'b1;
        log_src_q  <= gnt_idx;
        log_type_q <= pend_type[gnt_idx];
        log_addr_q <= pend_addr[gnt_idx];
      end else if (state == ST_LOGGED && bus.log_clr) begin
        log_vld_q <= 1'b0;
      end
    end
  end

  // A slot being granted this edge can accept a new event in its place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      ovf_q <= '0;
      for (int i = 0; i < 3; i++) begin
        pend_type[i] <= '0;
        pend_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.err_vld[i] && (!pend[i] || gnt[i])) begin
          pend[i]      <= 1'b1;
          pend_type[i] <= bus.err_type[2*i +: 2];
          pend_addr[i] <= bus.err_addr[i*ADDR_SIZE +: ADDR_SIZE];
        end else begin
          if (gnt[i]) pend[i] <= 1'b0;
          if (bus.err_vld[i]) ovf_q[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_n101_subsys_bpty_errctl.sv
// tb/tb_n101_subsys_bpty_errctl.sv - directed self-checking bench for n101_subsys_bpty_errctl
module tb_n101_subsys_bpty_errctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  n101_subsys_bpty_errctl_if #(.ADDR_SIZE(32), .CNT_W(8)) bus ();
  n101_subsys_bpty_errctl_if #(.ADDR_SIZE(32), .CNT_W(2)) sbus ();

  n101_subsys_bpty_errctl #(.ADDR_SIZE(32), .CNT_W(8), .ESC_THRESH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  n101_subsys_bpty_errctl #(.ADDR_SIZE(32), .CNT_W(2), .ESC_THRESH(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [2:0] v, input logic [5:0] t, input logic [95:0] a);
    bus.err_vld  = v;
    bus.err_type = t;
    bus.err_addr = a;
    tick();
    bus.err_vld  = 3'b000;
  endtask

  task automatic clr_pulse();
    bus.log_clr = 1'b1;
    tick();
    bus.log_clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.log_vld !== 1'b0) begin n_bad++; $display("FAIL reset_log_vld got %0b want 0", bus.log_vld); end
    n_cmp++; if (bus.log_addr !== 32'h0) begin n_bad++; $display("FAIL reset_log_addr got %h want 0", bus.log_addr); end
    n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", bus.err_cnt); end
    n_cmp++; if ({bus.ovf, bus.bpty_fatal, bus.log_src, bus.log_type} !== 8'h00) begin n_bad++; $display("FAIL reset_misc got %h want 00", {bus.ovf, bus.bpty_fatal, bus.log_src, bus.log_type}); end
  endtask

  task automatic test_single();
    do_reset();
    pulse(3'b001, 6'b00_00_10, {64'h0, 32'h0000_1000});
    n_cmp++; if (bus.log_vld !== 1'b0) begin n_bad++; $display("FAIL single_early_vld got %0b want 0", bus.log_vld); end
    tick();
    n_cmp++; if (bus.log_vld !== 1'b1) begin n_bad++; $display("FAIL single_vld got %0b want 1", bus.log_vld); end
    n_cmp++; if (bus.log_src !== 2'd0 || bus.log_type !== 2'b10) begin n_bad++; $display("FAIL single_src_type got %0d/%b want 0/10", bus.log_src, bus.log_type); end
    n_cmp++; if (bus.log_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL single_addr got %h want 00001000", bus.log_addr); end
    n_cmp++; if (bus.err_cnt !== 8'd1) begin n_bad++; $display("FAIL single_cnt got %0d want 1", bus.err_cnt); end
    tick();
    tick();
    n_cmp++; if (bus.log_vld !== 1'b1) begin n_bad++; $display("FAIL single_hold got %0b want 1", bus.log_vld); end
    clr_pulse();
    n_cmp++; if (bus.log_vld !== 1'b0) begin n_bad++; $display("FAIL single_clr got %0b want 0", bus.log_vld); end
    n_cmp++; if (bus.bpty_fatal !== 1'b0) begin n_bad++; $display("FAIL single_fatal got %0b want 0", bus.bpty_fatal); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(3'b111, 6'b11_01_00, {32'h0000_00C0, 32'h0000_00B0, 32'h0000_00A0});
    n_cmp++; if (bus.err_cnt !== 8'd3) begin n_bad++; $display("FAIL sim_cnt got %0d want 3", bus.err_cnt); end
    tick();
    n_cmp++; if (bus.log_src !== 2'd0 || bus.log_addr !== 32'hA0 || bus.log_vld !== 1'b1) begin n_bad++; $display("FAIL sim_first got src %0d addr %h want src 0 addr a0", bus.log_src, bus.log_addr); end
    clr_pulse();
    n_cmp++; if (bus.log_vld !== 1'b0) begin n_bad++; $display("FAIL sim_clr1 got %0b want 0", bus.log_vld); end
    tick();
    n_cmp++; if (bus.log_src !== 2'd1 || bus.log_type !== 2'b01 || bus.log_addr !== 32'hB0) begin n_bad++; $display("FAIL sim_second got src %0d type %b addr %h want 1/01/b0", bus.log_src, bus.log_type, bus.log_addr); end
    clr_pulse();
    tick();
    n_cmp++; if (bus.log_src !== 2'd2 || bus.log_type !== 2'b11 || bus.log_addr !== 32'hC0) begin n_bad++; $display("FAIL sim_third got src %0d type %b addr %h want 2/11/c0", bus.log_src, bus.log_type, bus.log_addr); end
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    pulse(3'b010, 6'b00_01_00, {32'h0, 32'h0000_0D10, 32'h0});
    tick();
    n_cmp++; if (bus.log_src !== 2'd1) begin n_bad++; $display("FAIL wrap_first got src %0d want 1", bus.log_src); end
    clr_pulse();
    pulse(3'b110, 6'b10_01_00, {32'h0000_0E20, 32'h0000_0D20, 32'h0});
    tick();
    n_cmp++; if (bus.log_src !== 2'd2 || bus.log_addr !== 32'hE20) begin n_bad++; $display("FAIL wrap_mem_first got src %0d addr %h want 2/e20", bus.log_src, bus.log_addr); end
    clr_pulse();
    tick();
    n_cmp++; if (bus.log_src !== 2'd1 || bus.log_addr !== 32'hD20) begin n_bad++; $display("FAIL wrap_dlm_next got src %0d addr %h want 1/d20", bus.log_src, bus.log_addr); end
    n_cmp++; if (bus.err_cnt !== 8'd3 || bus.bpty_fatal !== 1'b0) begin n_bad++; $display("FAIL wrap_cnt got %0d fatal %0b want 3/0", bus.err_cnt, bus.bpty_fatal); end
  endtask

  task automatic test_overflow();
    do_reset();
    pulse(3'b001, 6'b00_00_01, {64'h0, 32'h0000_0111});
    tick();
    pulse(3'b010, 6'b00_10_00, {32'h0, 32'h0000_0222, 32'h0});
    pulse(3'b010, 6'b00_11_00, {32'h0, 32'h0000_0333, 32'h0});
    n_cmp++; if (bus.ovf !== 3'b010) begin n_bad++; $display("FAIL ovf_set got %b want 010", bus.ovf); end
    n_cmp++; if (bus.log_src !== 2'd0 || bus.err_cnt !== 8'd3) begin n_bad++; $display("FAIL ovf_held got src %0d cnt %0d want 0/3", bus.log_src, bus.err_cnt); end
    clr_pulse();
    tick();
    n_cmp++; if (bus.log_src !== 2'd1 || bus.log_type !== 2'b10 || bus.log_addr !== 32'h222) begin n_bad++; $display("FAIL ovf_retained got src %0d type %b addr %h want 1/10/222", bus.log_src, bus.log_type, bus.log_addr); end
    n_cmp++; if (bus.ovf !== 3'b010) begin n_bad++; $display("FAIL ovf_sticky got %b want 010", bus.ovf); end
  endtask

  task automatic test_level_escalation();
    do_reset();
    bus.bptylvl = 1'b1;
    pulse(3'b100, 6'b01_00_00, {32'h0000_0F00, 64'h0});
    n_cmp++; if (bus.bpty_fatal !== 1'b0 || bus.log_vld !== 1'b0) begin n_bad++; $display("FAIL lvl_early got fatal %0b vld %0b want 0/0", bus.bpty_fatal, bus.log_vld); end
    tick();
    n_cmp++; if (bus.bpty_fatal !== 1'b1 || bus.log_vld !== 1'b1) begin n_bad++; $display("FAIL lvl_rise got fatal %0b vld %0b want 1/1", bus.bpty_fatal, bus.log_vld); end
    n_cmp++; if (bus.log_src !== 2'd2 || bus.log_addr !== 32'hF00) begin n_bad++; $display("FAIL lvl_log got src %0d addr %h want 2/f00", bus.log_src, bus.log_addr); end
    clr_pulse();
    tick();
    n_cmp++; if (bus.log_vld !== 1'b1 || bus.bpty_fatal !== 1'b1) begin n_bad++; $display("FAIL lvl_frozen got vld %0b fatal %0b want 1/1", bus.log_vld, bus.bpty_fatal); end
    bus.bptylvl = 1'b0;
  endtask

  task automatic test_threshold();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.bpty_fatal !== 1'b0) begin n_bad++; $display("FAIL thr_pre%0d got %0b want 0", k, bus.bpty_fatal); end
      pulse(3'b001, 6'b00_00_00, {64'h0, 32'(k)});
      n_cmp++; if (bus.err_cnt !== 8'(k + 1)) begin n_bad++; $display("FAIL thr_cnt%0d got %0d want %0d", k, bus.err_cnt, k + 1); end
      if (k < 3) begin
        tick();
        clr_pulse();
      end
    end
    n_cmp++; if (bus.bpty_fatal !== 1'b1) begin n_bad++; $display("FAIL thr_fatal got %0b want 1", bus.bpty_fatal); end
    tick();
    n_cmp++; if (bus.log_vld !== 1'b0) begin n_bad++; $display("FAIL thr_no_grant got %0b want 0", bus.log_vld); end
    pulse(3'b001, 6'b00_00_00, 96'h0);
    n_cmp++; if (bus.err_cnt !== 8'd5 || bus.ovf !== 3'b001) begin n_bad++; $display("FAIL thr_fatal_updates got cnt %0d ovf %b want 5/001", bus.err_cnt, bus.ovf); end
  endtask

  task automatic test_saturation();
    do_reset();
    sbus.err_vld = 3'b111;
    tick();
    n_cmp++; if (sbus.err_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_first got %0d want 3", sbus.err_cnt); end
    tick();
    sbus.err_vld = 3'b000;
    n_cmp++; if (sbus.err_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_hold got %0d want 3", sbus.err_cnt); end
    n_cmp++; if (sbus.bpty_fatal !== 1'b1) begin n_bad++; $display("FAIL sat_fatal got %0b want 1", sbus.bpty_fatal); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse(3'b001, 6'b00_00_01, {64'h0, 32'h0000_0AAA});
    tick();
    pulse(3'b110, 6'b10_10_00, {32'h0000_0CCC, 32'h0000_0BBB, 32'h0});
    n_cmp++; if (bus.log_vld !== 1'b1 || bus.err_cnt !== 8'd3) begin n_bad++; $display("FAIL mid_setup got vld %0b cnt %0d want 1/3", bus.log_vld, bus.err_cnt); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.log_vld, bus.log_src, bus.log_type, bus.ovf, bus.bpty_fatal} !== 9'h0 || bus.log_addr !== 32'h0 || bus.err_cnt !== 8'h0) begin n_bad++; $display("FAIL mid_async got vld %0b addr %h cnt %0d want all 0", bus.log_vld, bus.log_addr, bus.err_cnt); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.log_vld !== 1'b0) begin n_bad++; $display("FAIL mid_pending_flushed got %0b want 0", bus.log_vld); end
    pulse(3'b101, 6'b11_00_10, {32'h0000_0555, 32'h0, 32'h0000_0444});
    tick();
    n_cmp++; if (bus.log_src !== 2'd0 || bus.log_addr !== 32'h444 || bus.log_type !== 2'b10) begin n_bad++; $display("FAIL mid_ptr0 got src %0d addr %h type %b want 0/444/10", bus.log_src, bus.log_addr, bus.log_type); end
    clr_pulse();
    tick();
    n_cmp++; if (bus.log_src !== 2'd2 || bus.log_addr !== 32'h555) begin n_bad++; $display("FAIL mid_next got src %0d addr %h want 2/555", bus.log_src, bus.log_addr); end
  endtask

  initial begin
    bus.bptylvl  = 1'b0;
    bus.err_vld  = '0;
    bus.err_type = '0;
    bus.err_addr = '0;
    bus.log_clr  = 1'b0;
    sbus.bptylvl  = 1'b0;
    sbus.err_vld  = '0;
    sbus.err_type = '0;
    sbus.err_addr = '0;
    sbus.log_clr  = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_pointer_wrap();
    test_overflow();
    test_level_escalation();
    test_threshold();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
